// File: rtl/amber_wb_responder_if.sv
// Amber 128-bit wishbone classic bus between the core master and a responder.
interface amber_wb_responder_if;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic         i_wb_cyc;
    logic         i_wb_stb;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack;
    logic         o_wb_err;

    modport master (
        output i_wb_adr, i_wb_sel, i_wb_we,
        output i_wb_dat, i_wb_cyc, i_wb_stb,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_sel, i_wb_we,
        input  i_wb_dat, i_wb_cyc, i_wb_stb,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/amber_wb_responder.sv
// Wishbone classic responder: line RAM, wait states, error on unmapped lines,
// 32-bit backdoor loader and a capture port for committed stores.
module amber_wb_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    amber_wb_responder_if.slave  wb,
    input  logic                 i_ld_valid,
    input  logic [31:0]          i_ld_adr,
    input  logic [31:0]          i_ld_dat,
    output logic                 o_ld_ready,
    output logic                 o_wr_valid,
    output logic [31:0]          o_wr_adr,
    output logic [15:0]          o_wr_sel,
    output logic [127:0]         o_wr_dat
);
    localparam int unsigned LINES = 2 ** DEPTH_LOG2;
    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic         we;
        logic [127:0] dat;
    } req_t;

    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    req_t req, cur;
    logic [127:0] mem [LINES];

    logic [27:0] cur_line, ld_line;
    logic [DEPTH_LOG2-1:0] cur_idx, ld_idx;
    logic [1:0] ld_lane;
    logic cur_ok, ld_ok;
    logic sample, go_resp, commit, ld_we;
    logic unused_low;

    // In IDLE the live bus is the request; afterwards the latched copy is.
    assign cur = (state == S_IDLE) ?
        {wb.i_wb_adr, wb.i_wb_sel, wb.i_wb_we, wb.i_wb_dat} : req;

    assign cur_line = cur.adr[31:4] - BASE_ADDR[31:4];
    assign cur_ok   = (cur_line >> DEPTH_LOG2) == '0;
    assign cur_idx  = cur_line[DEPTH_LOG2-1:0];

    assign ld_line  = i_ld_adr[31:4] - BASE_ADDR[31:4];
    assign ld_ok    = (ld_line >> DEPTH_LOG2) == '0;
    assign ld_idx   = ld_line[DEPTH_LOG2-1:0];
    assign ld_lane  = i_ld_adr[3:2];

    assign unused_low = ^{cur.adr[3:0], i_ld_adr[1:0]};
    assign o_ld_ready = (state == S_IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sample  = 1'b0;
        go_resp = 1'b0;
        commit  = 1'b0;
        ld_we   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_ld_valid) begin
                    ld_we = ld_ok;
                end else if (wb.i_wb_cyc && wb.i_wb_stb) begin
                    sample = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!wb.i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                commit  = cur_ok && cur.we;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            req   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (sample) req <= cur;
        end
    end

    // Response registers are loaded on the edge that enters RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_err <= 1'b0;
            wb.o_wb_dat <= '0;
            o_wr_valid  <= 1'b0;
            o_wr_adr    <= '0;
            o_wr_sel    <= '0;
            o_wr_dat    <= '0;
        end else if (go_resp) begin
            wb.o_wb_ack <= cur_ok;
            wb.o_wb_err <= !cur_ok;
            wb.o_wb_dat <= (cur_ok && !cur.we) ? mem[cur_idx] : '0;
            o_wr_valid  <= cur_ok && cur.we;
            o_wr_adr    <= (cur_ok && cur.we) ? {cur.adr[31:4], 4'h0} : '0;
            o_wr_sel    <= (cur_ok && cur.we) ? cur.sel : '0;
            o_wr_dat    <= (cur_ok && cur.we) ? cur.dat : '0;
        end else begin
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_err <= 1'b0;
            wb.o_wb_dat <= '0;
            o_wr_valid  <= 1'b0;
            o_wr_adr    <= '0;
            o_wr_sel    <= '0;
            o_wr_dat    <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we && !rst) begin
            mem[ld_idx][{ld_lane, 5'd0} +: 32] <= i_ld_dat;
        end
        if (commit && !rst) begin
            for (int b = 0; b < 16; b++) begin
                if (cur.sel[b]) mem[cur_idx][8*b +: 8] <= cur.dat[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_amber_wb_responder.sv
// Bench: three responders (0/1/3 wait states) driven by directed and random
// transfers, checked against a line-array model of the bus rules.
module tb_amber_wb_responder;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0]  adr      [NI];
    logic [15:0]  sel      [NI];
    logic         we       [NI];
    logic [127:0] wdat     [NI];
    logic         cyc      [NI];
    logic         stb      [NI];
    logic [127:0] rdat     [NI];
    logic         ack      [NI];
    logic         err      [NI];
    logic         ld_valid [NI];
    logic [31:0]  ld_adr   [NI];
    logic [31:0]  ld_dat   [NI];
    logic         ld_ready [NI];
    logic         wr_valid [NI];
    logic [31:0]  wr_adr   [NI];
    logic [15:0]  wr_sel   [NI];
    logic [127:0] wr_dat   [NI];

    logic [127:0] mdl [NI][256];

    function automatic int unsigned ws(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [31:0] base(input int k);
        return (k == 2) ? 32'h0001_0000 : 32'h0000_0000;
    endfunction

    amber_wb_responder_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned W = ws(g);
        localparam logic [31:0] B = base(g);
        assign bus[g].i_wb_adr = adr[g];
        assign bus[g].i_wb_sel = sel[g];
        assign bus[g].i_wb_we  = we[g];
        assign bus[g].i_wb_dat = wdat[g];
        assign bus[g].i_wb_cyc = cyc[g];
        assign bus[g].i_wb_stb = stb[g];
        assign rdat[g] = bus[g].o_wb_dat;
        assign ack[g]  = bus[g].o_wb_ack;
        assign err[g]  = bus[g].o_wb_err;
        amber_wb_responder #(
            .DEPTH_LOG2(8), .WAIT_STATES(W), .BASE_ADDR(B)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .wb(bus[g]),
            .i_ld_valid(ld_valid[g]),
            .i_ld_adr(ld_adr[g]),
            .i_ld_dat(ld_dat[g]),
            .o_ld_ready(ld_ready[g]),
            .o_wr_valid(wr_valid[g]),
            .o_wr_adr(wr_adr[g]),
            .o_wr_sel(wr_sel[g]),
            .o_wr_dat(wr_dat[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base(k);
        return off < 32'h0000_1000;
    endfunction

    function automatic int line_of(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - base(k);
        return int'(off[11:4]);
    endfunction

    task automatic ld(input int k, input logic [31:0] a, input logic [31:0] d);
        int ln;
        ld_valid[k] = 1'b1;
        ld_adr[k] = a;
        ld_dat[k] = d;
        chk("ld_ready", ld_ready[k], 1);
        @(negedge clk);
        ld_valid[k] = 1'b0;
        ln = int'(a[3:2]);
        if (in_rng(k, a)) mdl[k][line_of(k, a)][32*ln +: 32] = d;
    endtask

    task automatic xfer(input int k, input logic [31:0] a, input logic w,
                        input logic [15:0] s, input logic [127:0] d,
                        output logic [127:0] got);
        logic ok;
        int li;
        logic [127:0] exp_rd;
        ok = in_rng(k, a);
        li = line_of(k, a);
        exp_rd = (ok && !w) ? mdl[k][li] : '0;
        adr[k] = a; we[k] = w; sel[k] = s; wdat[k] = d;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int i = 0; i < int'(ws(k)); i++) begin
            @(negedge clk);
            chk("early_resp", {ack[k], err[k]}, 0);
        end
        @(negedge clk);
        got = rdat[k];
        chk("ack", ack[k], ok);
        chk("err", err[k], !ok);
        chk("rdat", rdat[k], exp_rd);
        chk("wr_valid", wr_valid[k], ok && w);
        if (ok && w) begin
            chk("wr_adr", wr_adr[k], {a[31:4], 4'h0});
            chk("wr_sel", wr_sel[k], s);
            chk("wr_dat", wr_dat[k], d);
            for (int b = 0; b < 16; b++)
                if (s[b]) mdl[k][li][8*b +: 8] = d[8*b +: 8];
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(negedge clk);
        chk("one_cycle", {ack[k], err[k], wr_valid[k]}, 0);
        chk("rdat_idle", rdat[k], 0);
    endtask

    task automatic spacing(input int k);
        int n;
        int pos [3];
        n = 0;
        pos = '{0, 0, 0};
        adr[k] = base(k) + 32'h20; we[k] = 1'b0; sel[k] = '1;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int t = 1; t <= 40 && n < 3; t++) begin
            @(negedge clk);
            if (ack[k]) begin
                pos[n] = t;
                n++;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        chk("spc_count", n, 3);
        chk("spc_first", pos[0], 1 + ws(k));
        chk("spc_gap1", pos[1] - pos[0], 2 + ws(k));
        chk("spc_gap2", pos[2] - pos[1], 2 + ws(k));
        @(negedge clk);
        chk("spc_end", ack[k], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] d;
        logic [31:0] a;
        logic [31:0] v;
        logic [15:0] s;
        int r;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            adr[k] = '0; sel[k] = '0; we[k] = 1'b0; wdat[k] = '0;
            cyc[k] = 1'b0; stb[k] = 1'b0;
            ld_valid[k] = 1'b0; ld_adr[k] = '0; ld_dat[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_ack", {ack[k], err[k], wr_valid[k]}, 0);
            chk("rst_dat", rdat[k], 0);
            chk("rst_wr", {wr_adr[k], wr_sel[k], wr_dat[k]}, 0);
            chk("rst_ldrdy", ld_ready[k], 1);
        end
        rst = 1'b0;

        // Preload every line so nothing reads back uninitialised.
        for (int l = 0; l < 256; l++) begin
            for (int ln = 0; ln < 4; ln++) begin
                for (int k = 0; k < NI; k++) begin
                    v = $urandom;
                    ld_valid[k] = 1'b1;
                    ld_adr[k] = base(k) + 32'(l * 16 + ln * 4);
                    ld_dat[k] = v;
                    mdl[k][l][32*ln +: 32] = v;
                end
                @(negedge clk);
            end
        end
        for (int k = 0; k < NI; k++) ld_valid[k] = 1'b0;

        ld(1, 32'h0, 32'hE3A01005);
        ld(1, 32'h4, 32'hE3A02007);
        ld(1, 32'h8, 32'hE0813002);
        ld(1, 32'hC, 32'hE5803000);
        xfer(1, 32'h0, 1'b0, '1, '0, got);
        chk("t1_line", got,
            128'hE5803000_E0813002_E3A02007_E3A01005);

        for (int i = 0; i < 4; i++) ld(1, 32'h10 + 32'(4*i), 32'h11111111);
        d = {$urandom, $urandom, $urandom, 32'hDEADBEEF};
        xfer(1, 32'h10, 1'b1, 16'h000F, d, got);
        xfer(1, 32'h10, 1'b0, '1, '0, got);
        chk("t2_line", got,
            128'h11111111_11111111_11111111_DEADBEEF);

        xfer(1, 32'h1000, 1'b0, '1, '0, got);
        xfer(1, 32'h1000, 1'b1, '1, {4{32'hA5A5A5A5}}, got);
        xfer(1, 32'h0FF8, 1'b0, '1, '0, got);
        xfer(1, 32'h0, 1'b0, '1, '0, got);
        xfer(2, base(2) - 32'h10, 1'b0, '1, '0, got);
        xfer(2, base(2) + 32'h0FF0, 1'b0, '1, '0, got);

        a = base(2) + 32'h40;
        adr[2] = a; we[2] = 1'b1; sel[2] = '1;
        wdat[2] = {4{32'hCAFEF00D}};
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(negedge clk);
        chk("abort_w1", {ack[2], err[2]}, 0);
        @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_quiet", {ack[2], err[2], wr_valid[2]}, 0);
        end
        xfer(2, a, 1'b0, '1, '0, got);

        for (int k = 0; k < NI; k++) spacing(k);

        a = base(2) + 32'h50;
        adr[2] = a; we[2] = 1'b0; sel[2] = '1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", ld_ready[2], 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait_rdy", ld_ready[2], 1);
        chk("rst_wait_out", {ack[2], err[2], wr_valid[2]}, 0);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(2, a, 1'b0, '1, '0, got);

        adr[1] = 32'h60; we[1] = 1'b1; sel[1] = '1;
        wdat[1] = {4{32'h0BADC0DE}};
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("resp_wrv", wr_valid[1], 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_resp_ack", ack[1], 0);
        chk("rst_resp_wrv", wr_valid[1], 0);
        chk("rst_resp_wrd", wr_dat[1], 0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(1, 32'h60, 1'b0, '1, '0, got);

        v = $urandom;
        ld_valid[1] = 1'b1; ld_adr[1] = 32'h34; ld_dat[1] = v;
        adr[1] = 32'h30; we[1] = 1'b0; sel[1] = '1;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        chk("t7_ldrdy", ld_ready[1], 1);
        @(negedge clk);
        ld_valid[1] = 1'b0;
        mdl[1][3][63:32] = v;
        chk("t7_noack", ack[1], 0);
        for (int i = 0; i < int'(ws(1)); i++) begin
            @(negedge clk);
            chk("t7_wait", ack[1], 0);
        end
        @(negedge clk);
        chk("t7_ack", ack[1], 1);
        chk("t7_line", rdat[1], mdl[1][3]);
        chk("t7_word", rdat[1][63:32], v);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);

        xfer(1, 32'h70, 1'b1, 16'h0, {4{$urandom}}, got);
        xfer(1, 32'h70, 1'b0, '1, '0, got);

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if ($urandom_range(0, 7) == 0) a = $urandom;
                else a = base(k) + 32'($urandom_range(0, 7) * 16)
                         + 32'($urandom_range(0, 15));
                d = {$urandom, $urandom, $urandom, $urandom};
                s = ($urandom_range(0, 3) == 0) ? '1 : 16'($urandom);
                if (r < 2) ld(k, a, d[31:0]);
                else if (r < 6) xfer(k, a, 1'b0, '1, '0, got);
                else xfer(k, a, 1'b1, s, d, got);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
